// File: rtl/data_bus_bridge_pkg.sv
// Shared constants for the LSU-to-bus bridge: FSM encoding, bus widths, abort data.
package data_bus_bridge_pkg;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;
    localparam int unsigned BUS_MW = BUS_DW / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [BUS_DW-1:0] ERR_DATA_DEFAULT = 32'h0;

endpackage

// File: rtl/data_bus_bridge_bus_timeout_counter.sv
// Counts in-flight cycles of one bus access and flags the last allowed cycle.
// Latency: expired_o is combinational from the count; TIMEOUT=0 ties it low.
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk_i, reset_i, clr_i, en_i};
            assign expired_o     = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = $clog2(TIMEOUT + 1);

            logic [CW-1:0] count_q, count_d;

            always_comb begin
                count_d = count_q;
                if (clr_i) begin
                    count_d = '0;
                end else if (en_i) begin
                    count_d = count_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expired_o = en_i && (count_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/data_bus_bridge.sv
// Turns a single-cycle LSU request into a valid/ready bus access and stalls the pipe until done.
// Latency: store 2 stall cycles, load 3, plus one per ready/rvalid wait; one IDLE cycle between accesses.
module data_bus_bridge
    import data_bus_bridge_pkg::*;
#(
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [BUS_DW-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic [BUS_AW-1:0] addr_i,
    input  logic [BUS_DW-1:0] data_i,
    input  logic [BUS_MW-1:0] wmask_i,
    input  logic              wen_i,
    output logic              stall_o,
    output logic [BUS_DW-1:0] read_data_o,
    output logic              err_o,
    output logic              bus_valid_o,
    input  logic              bus_ready_i,
    output logic [BUS_AW-1:0] bus_addr_o,
    output logic [BUS_DW-1:0] bus_wdata_o,
    output logic [BUS_MW-1:0] bus_wmask_o,
    output logic              bus_we_o,
    input  logic              bus_rvalid_i,
    input  logic [BUS_DW-1:0] bus_rdata_i
);

    logic [1:0]        state_q, state_d;
    logic [BUS_AW-1:0] addr_q, addr_d;
    logic [BUS_DW-1:0] wdata_q, wdata_d;
    logic [BUS_MW-1:0] wmask_q, wmask_d;
    logic              we_q, we_d;
    logic [BUS_DW-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              in_flight;
    logic              expired;

    assign in_flight = (state_q == ST_REQ) || (state_q == ST_RESP);

    bus_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clr_i    (state_q == ST_IDLE),
        .en_i     (in_flight),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    wdata_d = data_i;
                    wmask_d = wen_i ? '0 : wmask_i;
                    we_d    = ~wen_i;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A completing handshake on the last allowed cycle beats the abort.
                if (bus_ready_i) begin
                    state_d = we_q ? ST_DONE : ST_RESP;
                end else if (expired) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = ERR_DATA;
                end
            end
            ST_RESP: begin
                if (bus_rvalid_i) begin
                    rdata_d = bus_rdata_i;
                    state_d = ST_DONE;
                end else if (expired) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign stall_o     = ((state_q == ST_IDLE) && req_i) || in_flight;
    assign bus_valid_o = (state_q == ST_REQ);
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_wmask_o = wmask_q;
    assign bus_we_o    = we_q;
    assign read_data_o = rdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Scoreboard bench: stimulus queues expected bus requests and completions, a negedge monitor checks them.
module tb_data_bus_bridge;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        we;
    } req_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } done_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wen, bus_ready, bus_rvalid;
    logic [31:0] addr, wdata, bus_rdata;
    logic [3:0]  wmask;
    logic        stall, err, bvalid, bwe;
    logic [31:0] rd, baddr, bwdata;
    logic [3:0]  bwmask;

    logic        t_req, t_wen, t_ready, t_rvalid;
    logic [31:0] t_addr, t_rdata;
    logic        t_stall, t_err, t_bvalid, t_bwe;
    logic [31:0] t_rd, t_baddr, t_bwdata;
    logic [3:0]  t_bwmask;

    int n_tests = 0;
    int n_fail  = 0;

    req_t        exp_req_q[$];
    done_t       exp_done_q[$];
    logic [31:0] exp_rd = 32'h0;
    bit          prev_stall = 1'b0;

    always #5 clk = ~clk;

    data_bus_bridge dut (
        .clk_i(clk), .reset_i(rst), .req_i(req), .addr_i(addr), .data_i(wdata),
        .wmask_i(wmask), .wen_i(wen), .stall_o(stall), .read_data_o(rd), .err_o(err),
        .bus_valid_o(bvalid), .bus_ready_i(bus_ready), .bus_addr_o(baddr),
        .bus_wdata_o(bwdata), .bus_wmask_o(bwmask), .bus_we_o(bwe),
        .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
    );

    data_bus_bridge #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut_to (
        .clk_i(clk), .reset_i(rst), .req_i(t_req), .addr_i(t_addr), .data_i(32'h0),
        .wmask_i(4'hF), .wen_i(t_wen), .stall_o(t_stall), .read_data_o(t_rd), .err_o(t_err),
        .bus_valid_o(t_bvalid), .bus_ready_i(t_ready), .bus_addr_o(t_baddr),
        .bus_wdata_o(t_bwdata), .bus_wmask_o(t_bwmask), .bus_we_o(t_bwe),
        .bus_rvalid_i(t_rvalid), .bus_rdata_i(t_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: request fields against the queue head while valid, completions on stall release.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bvalid) begin
                if (exp_req_q.size() == 0) begin
                    check("unexpected_bus_req", 32'h1, 32'h0);
                end else begin
                    check("bus_addr", baddr, exp_req_q[0].addr);
                    check("bus_wdata", bwdata, exp_req_q[0].wdata);
                    check("bus_wmask", {28'h0, bwmask}, {28'h0, exp_req_q[0].mask});
                    check("bus_we", {31'h0, bwe}, {31'h0, exp_req_q[0].we});
                    if (bus_ready) void'(exp_req_q.pop_front());
                end
            end
            if (prev_stall && !stall) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", 32'h1, 32'h0);
                end else begin
                    check("done_read_data", rd, exp_done_q[0].rd);
                    check("done_err", {31'h0, err}, {31'h0, exp_done_q[0].err});
                    void'(exp_done_q.pop_front());
                end
            end
            prev_stall = stall;
        end
    end

    task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          input logic w, input int rdy_dly, input int rv_dly,
                          input logic [31:0] rdata, output int nstall);
        req_t  r;
        done_t e;
        int    h;
        bit    done;
        r.addr  = a;
        r.wdata = d;
        r.mask  = w ? 4'h0 : m;
        r.we    = ~w;
        exp_req_q.push_back(r);
        if (w) exp_rd = rdata;
        e.rd  = exp_rd;
        e.err = 1'b0;
        exp_done_q.push_back(e);
        h      = 1 + rdy_dly;
        nstall = 0;
        done   = 1'b0;
        req = 1'b1; addr = a; wdata = d; wmask = m; wen = w;
        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0) tick();
            bus_ready  = (rdy_dly == 0) || (c >= h);
            bus_rvalid = w && (c == h + rv_dly);
            bus_rdata  = (c == h + rv_dly) ? rdata : 32'h0;
            #1;
            if (c == 0) check("idle_before_accept", {31'h0, bvalid}, 32'h0);
            if (stall) nstall++;
            else done = 1'b1;
        end
        if (!done) check("txn_cycle_bound", 32'h1, 32'h0);
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns, nv;
        rst = 1'b1;
        req = 1'b0; addr = 32'h0; wdata = 32'h0; wmask = 4'h0; wen = 1'b1;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        t_req = 1'b0; t_addr = 32'h0; t_wen = 1'b1; t_ready = 1'b0; t_rvalid = 1'b0; t_rdata = 32'h0;
        #23 rst = 1'b0;
        tick();

        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_valid", {31'h0, bvalid}, 32'h0);
        check("rst_addr", baddr, 32'h0);
        check("rst_wdata", bwdata, 32'h0);
        check("rst_wmask", {28'h0, bwmask}, 32'h0);
        check("rst_we", {31'h0, bwe}, 32'h0);
        check("rst_rd", rd, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);

        // Store, ready already high
        do_txn(32'h100, 32'hAABBCCDD, 4'b1100, 1'b0, 0, 0, 32'h0, ns);
        check("store_stall_cycles", ns, 32'd2);
        req = 1'b0;
        tick();

        // Load, ready delayed 3 cycles, rvalid 2 cycles after handshake
        do_txn(32'h200, 32'h0, 4'hF, 1'b1, 3, 2, 32'h12345678, ns);
        check("load_stall_cycles", ns, 32'd7);
        req = 1'b0;
        tick();
        check("load_hold_1", rd, 32'h12345678);
        tick();
        check("load_hold_2", rd, 32'h12345678);

        // Misaligned halves back-to-back
        do_txn(32'h104, 32'h0, 4'h0, 1'b1, 0, 1, 32'h11112222, ns);
        check("mis_first_stall", ns, 32'd3);
        tick();
        do_txn(32'h108, 32'h0, 4'h0, 1'b1, 0, 1, 32'h33334444, ns);
        check("mis_second_stall", ns, 32'd3);
        req = 1'b0;
        tick();
        check("mis_final_rd", rd, 32'h33334444);

        // Reset during RESP, then a stale rvalid
        exp_req_q.push_back('{addr: 32'h300, wdata: 32'h0, mask: 4'h0, we: 1'b0});
        req = 1'b1; addr = 32'h300; wdata = 32'h0; wmask = 4'hF; wen = 1'b1; bus_ready = 1'b1;
        tick();
        tick();
        bus_ready = 1'b0;
        #1;
        check("resp_stalled", {31'h0, stall}, 32'h1);
        rst = 1'b1;
        req = 1'b0;
        #1;
        check("mrst_stall", {31'h0, stall}, 32'h0);
        check("mrst_valid", {31'h0, bvalid}, 32'h0);
        check("mrst_addr", baddr, 32'h0);
        check("mrst_wmask", {28'h0, bwmask}, 32'h0);
        check("mrst_we", {31'h0, bwe}, 32'h0);
        check("mrst_rd", rd, 32'h0);
        check("mrst_err", {31'h0, err}, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        exp_rd = 32'h0;
        tick();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hBAD0BAD0;
        tick();
        bus_rvalid = 1'b0;
        #1;
        check("stale_rvalid_rd", rd, 32'h0);
        check("stale_rvalid_stall", {31'h0, stall}, 32'h0);
        check("stale_rvalid_valid", {31'h0, bvalid}, 32'h0);
        tick();
        do_txn(32'h400, 32'h0, 4'h0, 1'b1, 0, 1, 32'hCAFEF00D, ns);
        check("post_reset_stall", ns, 32'd3);
        req = 1'b0;
        tick();

        // TIMEOUT=4: load with ready never asserted
        t_req = 1'b1; t_addr = 32'h500; t_wen = 1'b1;
        ns = 0; nv = 0;
        for (int c = 0; c < 32; c++) begin
            #1;
            if (!t_stall) break;
            ns++;
            if (t_bvalid) nv++;
            tick();
        end
        check("to_stall_cycles", ns, 32'd5);
        check("to_valid_cycles", nv, 32'd4);
        check("to_err_pulse", {31'h0, t_err}, 32'h1);
        check("to_rd_errdata", t_rd, 32'hDEADBEEF);
        check("to_valid_dropped", {31'h0, t_bvalid}, 32'h0);
        t_req = 1'b0;
        tick();
        #1;
        check("to_err_single", {31'h0, t_err}, 32'h0);
        check("to_rd_hold", t_rd, 32'hDEADBEEF);

        // TIMEOUT=4: handshake on the last allowed cycle wins
        tick();
        t_req = 1'b1; t_addr = 32'h504;
        ns = 0;
        for (int c = 0; c < 32; c++) begin
            t_ready  = (c == 4);
            t_rvalid = (c == 5);
            t_rdata  = (c == 5) ? 32'h0BADF00D : 32'h0;
            #1;
            if (!t_stall) break;
            ns++;
            tick();
        end
        t_ready = 1'b0; t_rvalid = 1'b0; t_req = 1'b0;
        check("to_race_stall", ns, 32'd6);
        check("to_race_err", {31'h0, t_err}, 32'h0);
        check("to_race_rd", t_rd, 32'h0BADF00D);
        tick();
        tick();

        check("req_queue_drained", exp_req_q.size(), 32'd0);
        check("done_queue_drained", exp_done_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_bus_bridge.md
# data_bus_bridge

Sits directly downstream of the load/store unit. Converts its single-cycle data-memory request (word address, shifted write data, byte mask, active-low write enable) into a valid/ready bus transaction. Stalls the pipeline until the transaction completes, then holds captured load data stable for the MEM-stage byte-extraction logic. Each half of a misaligned access arrives as an independent request; the bridge needs no misalignment awareness.

## Interface
Parameters:
- TIMEOUT, 255: max cycles spent in REQ+RESP before abort; 0 disables timeout.
- ERR_DATA, 32'h0: value loaded into read_data_o on timeout.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- req_i  in  1  EX stage holds a load or store this cycle.
- addr_i  in  32  word-aligned address from LSU.
- data_i  in  32  byte-lane-aligned write data.
- wmask_i  in  4  byte write mask.
- wen_i  in  1  active-low write enable (0 = store, 1 = load).
- stall_o  out  1  freeze PC/IF/ID/EX; combinational.
- read_data_o  out  32  registered load data to LSU MEM stage.
- err_o  out  1  one-cycle pulse on timeout abort.
- bus_valid_o  out  1  request valid.
- bus_ready_i  in  1  slave accepts request.
- bus_addr_o  out  32  registered request address.
- bus_wdata_o  out  32  registered write data.
- bus_wmask_o  out  4  registered mask; forced 4'b0000 for loads.
- bus_we_o  out  1  active-high write strobe (= ~wen_i captured).
- bus_rvalid_i  in  1  read response valid.
- bus_rdata_i  in  32  read response data.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: on req_i=1, capture addr/data/mask/we into bus registers and go to REQ. Otherwise stay.
- REQ: bus_valid_o=1. Request fields are stable until handshake (bus_valid_o & bus_ready_i). On handshake, a store goes to DONE (posted write, no response); a load goes to RESP.
- RESP: bus_valid_o=0. On bus_rvalid_i=1: read_data_o <= bus_rdata_i, go to DONE. bus_rvalid_i is ignored in every other state.
- DONE: stall released. The instruction leaves EX at the end of this cycle. req_i is ignored. Next state IDLE.
- stall_o = (state==IDLE & req_i) | state==REQ | state==RESP.
- read_data_o changes only on a load response or a timeout. It otherwise holds, so it stays valid through the following MEM cycle.
- Timeout counter: cleared in IDLE and incremented each cycle in REQ or RESP. When count == TIMEOUT-1 and no completing event occurs that cycle: go to DONE, drop bus_valid_o, load read_data_o <= ERR_DATA only if the access is a load, and pulse err_o in DONE.
- A completing handshake or rvalid on the timeout cycle wins over the abort.
- An accepted request cannot be cancelled. The block has no flush input.

## Timing
- Reset values: state IDLE, bus_valid_o 0, bus_addr_o/bus_wdata_o 0, bus_wmask_o 0, bus_we_o 0, read_data_o 0, err_o 0, counter 0. stall_o follows req_i while in IDLE.
- Reset asserted mid-transaction returns everything to reset values immediately (asynchronous). Any outstanding bus response after reset is ignored because the FSM is in IDLE.
- Store with ready already high: req cycle 0 (IDLE), handshake cycle 1 (REQ), DONE cycle 2. stall_o is high for 2 cycles.
- Load, ready in cycle 1, rvalid in cycle 2: DONE in cycle 3, read_data_o valid from cycle 3. stall_o is high for 3 cycles.
- Back-to-back requests: at least one IDLE cycle separates DONE from the next acceptance.
- Each wait cycle of bus_ready_i or bus_rvalid_i adds exactly one stall cycle.

## Structure
- Shared core package holds:
  - state encoding constants (IDLE=2'd0, REQ=2'd1, RESP=2'd2, DONE=2'd3);
  - the ERR_DATA default;
  - the bus width constants.
- One sub-module, bus_timeout_counter: parameter TIMEOUT, inputs clr/en, output expired. It is tied off when TIMEOUT=0.

## Test plan
- Store addr 0x100, data 0xAABBCCDD, mask 4'b1100, wen_i=0, ready=1 -> bus_valid_o one cycle with bus_we_o=1 and bus_wmask_o=4'b1100; stall_o high exactly 2 cycles; read_data_o unchanged.
- Load addr 0x200, ready delayed 3 cycles, rvalid 2 cycles after handshake with rdata 0x12345678 -> request fields stable across the waits; stall_o high 7 cycles; read_data_o=0x12345678 held through the next 2 cycles.
- Misaligned pair: load at 0x104 then 0x108, issued back-to-back -> two separate transactions with one IDLE cycle between; read_data_o equals the second response after the second DONE.
- TIMEOUT=4, load with ready never asserted -> DONE after 4 REQ cycles; err_o is a single pulse; read_data_o=ERR_DATA; bus_valid_o drops.
- reset_i pulsed during RESP, then a stale rvalid arrives -> all outputs return to reset values; the stale rvalid is ignored; the next request proceeds normally.
